pic_service_ctrl: RTL and testbench
===================================

PIC_SERVICE_CTRL -- requirements
Module: pic_service_ctrl

Interface
REQ-001 SHALL have parameter EDGEN_INIT, 8'h00, value written to the PIC edge-enable register (adr 2'b00) at init.
REQ-002 SHALL have parameter POL_INIT, 8'h00, value written to the PIC polarity register (adr 2'b01) at init.
REQ-003 SHALL have parameter MASK_INIT, 8'hFF, value written to the PIC mask register (adr 2'b10) at init; 1 = masked.
REQ-004 SHALL have parameter TIMEOUT, 16, the maximum number of cycles to wait for m_ack_i per bus transaction.
REQ-005 SHALL have ports clk_i in 1 (single clock, rising edge) and rst_i in 1 (synchronous, active-high reset).
REQ-006 SHALL have Wishbone master ports m_cyc_o out 1, m_stb_o out 1, m_we_o out 1, m_adr_o out 2, m_dat_o out 8, m_dat_i in 8 (PIC read data), and m_ack_i in 1.
REQ-007 SHALL have ports int_i in 1 (PIC interrupt request) and eoi_i in 1 (CPU end-of-interrupt pulse).
REQ-008 SHALL have ports vec_valid_o out 1, vec_o out 3 (granted IRQ index), and vec_ready_i in 1 (CPU accepts vector).
REQ-009 SHALL have status outputs init_done_o out 1, busy_o out 1, spurious_o out 1 (one-cycle pulse), and err_o out 1 (sticky).

Function
REQ-010 SHALL implement FSM states INIT_EDGE, INIT_POL, INIT_MASK, IDLE, RD_PEND, ARB, PRESENT, WAIT_EOI, CLR.
REQ-011 Init sequence SHALL be INIT_EDGE -> INIT_POL -> INIT_MASK -> IDLE, with each state doing one write of its parameter to its address.
REQ-012 Bus rule: m_cyc_o and m_stb_o SHALL be asserted together with stable adr/we/dat and held until m_ack_i, then dropped in the next cycle; there SHALL be at least one idle cycle between transactions and never more than one transaction outstanding.
REQ-013 Read data SHALL be captured from m_dat_i in the cycle in which m_ack_i is high.
REQ-014 A timeout counter SHALL reset at the start of each transaction; if it reaches TIMEOUT without m_ack_i, cyc/stb SHALL drop, err_o SHALL set, and the FSM SHALL advance as if the transaction had been acked (read data treated as 8'h00).
REQ-015 init_done_o SHALL set on leaving INIT_MASK only if all three init writes were acked.
REQ-016 In IDLE, int_i=1 SHALL move the FSM to RD_PEND in the next cycle; int_i SHALL be ignored in all other states.
REQ-017 RD_PEND SHALL read adr 2'b11 and form eligible = pending & ~MASK_INIT.
REQ-018 If eligible==0, the controller SHALL pulse spurious_o for one cycle and return to IDLE.
REQ-019 ARB SHALL take one cycle and grant the first set bit of eligible searched upward from rr_ptr, wrapping 7 -> 0.
REQ-020 rr_ptr SHALL reset to 0, and on each grant SHALL update to (grant+1) mod 8.
REQ-021 PRESENT SHALL drive vec_valid_o=1 with vec_o=grant until vec_ready_i=1, then go to WAIT_EOI; vec_o SHALL stay stable while valid.
REQ-022 eoi_i SHALL be ignored outside WAIT_EOI; in WAIT_EOI, eoi_i=1 SHALL move the FSM to CLR.
REQ-023 CLR SHALL write adr 2'b11 with data = 1<<grant (write-1-to-clear), then return to IDLE.
REQ-024 busy_o SHALL be 1 in every state except IDLE.
REQ-025 Simultaneous vec_ready_i and eoi_i in PRESENT SHALL cause only the PRESENT -> WAIT_EOI transition; that eoi_i is not remembered.

Reset
REQ-026 While rst_i=1 at a rising edge, the FSM SHALL enter INIT_EDGE and all outputs SHALL be 0 on the following cycle, including m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, vec_valid_o, vec_o, init_done_o, busy_o (INIT_EDGE forces busy_o=1 once rst_i is released), spurious_o, and err_o.
REQ-027 Reset mid-transaction SHALL abandon the bus cycle immediately, with cyc/stb low the next cycle, and clear rr_ptr and the grant.
REQ-028 After rst_i deasserts, the first init write SHALL start within 1 cycle.

Verification
REQ-029 Init: release reset with a slave acking in 1 cycle -> three writes (00:EDGEN_INIT, 01:POL_INIT, 10:MASK_INIT) in order, then init_done_o=1 and err_o=0.
REQ-030 Service: MASK_INIT=8'h00, int_i=1, pending read 8'h04 -> vec_o=2 presented; after vec_ready then eoi -> write adr 11 data 8'h04, then IDLE.
REQ-031 Round robin: pending 8'h81 on three services -> grants 0, 7, 0.
REQ-032 Spurious: pending read 8'h00 -> spurious_o pulses once, no clear write, FSM returns to IDLE.
REQ-033 Timeout: slave never acks in INIT_POL -> cyc/stb drop after TIMEOUT cycles, err_o=1, init_done_o=0, FSM still reaches IDLE.
REQ-034 Reset during WAIT_EOI -> vec_valid_o=0 and busy_o=0 the next cycle, then the init sequence restarts.

Source files
------------

// File: rtl/pic_service_ctrl.sv
// Wishbone master that initialises an 8-input PIC, then services its interrupts:
// reads pending, arbitrates round-robin, presents the vector, and clears on EOI.
module pic_service_ctrl #(
    parameter logic [7:0]  EDGEN_INIT = 8'h00,
    parameter logic [7:0]  POL_INIT   = 8'h00,
    parameter logic [7:0]  MASK_INIT  = 8'hFF,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic       m_cyc_o,
    output logic       m_stb_o,
    output logic       m_we_o,
    output logic [1:0] m_adr_o,
    output logic [7:0] m_dat_o,
    input  logic [7:0] m_dat_i,
    input  logic       m_ack_i,
    input  logic       int_i,
    input  logic       eoi_i,
    output logic       vec_valid_o,
    output logic [2:0] vec_o,
    input  logic       vec_ready_i,
    output logic       init_done_o,
    output logic       busy_o,
    output logic       spurious_o,
    output logic       err_o
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        INIT_EDGE, INIT_POL, INIT_MASK, IDLE, RD_PEND, ARB, PRESENT, WAIT_EOI, CLR
    } state_e;

    state_e        state_q, state_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [1:0]    adr_q, adr_d;
    logic [7:0]    dat_q, dat_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          init_ok_q, init_ok_d;
    logic          init_done_q, init_done_d;
    logic          busy_q, busy_d;
    logic          spur_q, spur_d;
    logic          err_q, err_d;
    logic [7:0]    elig_q, elig_d;
    logic [2:0]    rr_q, rr_d;
    logic [2:0]    grant_q, grant_d;
    logic          vv_q, vv_d;
    logic [2:0]    vec_q, vec_d;

    logic          bus_state, timed_out, xfer_done, arb_hit;
    logic [7:0]    rd_data;
    logic [2:0]    cand, arb_idx;

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        tmo_d       = tmo_q;
        init_ok_d   = init_ok_q;
        init_done_d = init_done_q;
        spur_d      = 1'b0;
        err_d       = err_q;
        elig_d      = elig_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        vv_d        = vv_q;
        vec_d       = vec_q;
        cand        = '0;
        arb_idx     = '0;
        arb_hit     = 1'b0;

        bus_state = (state_q == INIT_EDGE) || (state_q == INIT_POL) || (state_q == INIT_MASK) ||
                    (state_q == RD_PEND) || (state_q == CLR);
        timed_out = cyc_q && !m_ack_i && (tmo_q == TW'(TIMEOUT - 1));
        xfer_done = cyc_q && (m_ack_i || timed_out);
        rd_data   = m_ack_i ? m_dat_i : '0;

        // Each bus state issues exactly one transaction; its first cycle doubles as the idle gap.
        if (bus_state && !cyc_q) begin
            cyc_d = 1'b1;
            tmo_d = '0;
            case (state_q)
                INIT_EDGE: begin we_d = 1'b1; adr_d = 2'b00; dat_d = EDGEN_INIT; end
                INIT_POL:  begin we_d = 1'b1; adr_d = 2'b01; dat_d = POL_INIT; end
                INIT_MASK: begin we_d = 1'b1; adr_d = 2'b10; dat_d = MASK_INIT; end
                RD_PEND:   begin we_d = 1'b0; adr_d = 2'b11; dat_d = '0; end
                default:   begin we_d = 1'b1; adr_d = 2'b11; dat_d = 8'b1 << grant_q; end
            endcase
        end else if (cyc_q) begin
            if (xfer_done) cyc_d = 1'b0;
            else           tmo_d = tmo_q + TW'(1);
            if (timed_out) err_d = 1'b1;
        end

        for (int unsigned i = 0; i < 8; i++) begin
            cand = rr_q + 3'(i);
            if (!arb_hit && elig_q[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end

        case (state_q)
            INIT_EDGE: if (xfer_done) begin
                if (timed_out) init_ok_d = 1'b0;
                state_d = INIT_POL;
            end
            INIT_POL: if (xfer_done) begin
                if (timed_out) init_ok_d = 1'b0;
                state_d = INIT_MASK;
            end
            INIT_MASK: if (xfer_done) begin
                init_done_d = init_ok_q && !timed_out;
                state_d     = IDLE;
            end
            IDLE: if (int_i) state_d = RD_PEND;
            RD_PEND: if (xfer_done) begin
                elig_d = rd_data & ~MASK_INIT;
                if ((rd_data & ~MASK_INIT) == 8'h00) begin
                    spur_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = ARB;
                end
            end
            ARB: begin
                grant_d = arb_idx;
                vec_d   = arb_idx;
                rr_d    = arb_idx + 3'd1;
                vv_d    = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: if (vec_ready_i) begin
                vv_d    = 1'b0;
                state_d = WAIT_EOI;
            end
            WAIT_EOI: if (eoi_i) state_d = CLR;
            CLR: if (xfer_done) state_d = IDLE;
            default: state_d = INIT_EDGE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= INIT_EDGE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            tmo_q       <= '0;
            init_ok_q   <= 1'b1;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
            spur_q      <= 1'b0;
            err_q       <= 1'b0;
            elig_q      <= '0;
            rr_q        <= '0;
            grant_q     <= '0;
            vv_q        <= 1'b0;
            vec_q       <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            tmo_q       <= tmo_d;
            init_ok_q   <= init_ok_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
            spur_q      <= spur_d;
            err_q       <= err_d;
            elig_q      <= elig_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            vv_q        <= vv_d;
            vec_q       <= vec_d;
        end
    end

    assign m_cyc_o     = cyc_q;
    assign m_stb_o     = cyc_q;
    assign m_we_o      = we_q;
    assign m_adr_o     = adr_q;
    assign m_dat_o     = dat_q;
    assign vec_valid_o = vv_q;
    assign vec_o       = vec_q;
    assign init_done_o = init_done_q;
    assign busy_o      = busy_q;
    assign spurious_o  = spur_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_pic_service_ctrl.sv
// Directed bench for pic_service_ctrl with a 1-cycle-ack PIC slave model
// that logs writes and can withhold ack for one address.
module tb_pic_service_ctrl;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       m_cyc_o, m_stb_o, m_we_o;
    logic [1:0] m_adr_o;
    logic [7:0] m_dat_o, m_dat_i;
    logic       m_ack_i;
    logic       int_i, eoi_i, vec_ready_i;
    logic       vec_valid_o;
    logic [2:0] vec_o;
    logic       init_done_o, busy_o, spurious_o, err_o;

    logic [7:0] pend_val;
    logic       nack_en;
    logic [1:0] nack_adr;

    logic [9:0] wr_log[$];
    int         spur_cnt  = 0;
    int         bus_viol  = 0;
    int         run       = 0;
    int         run_len[4];
    logic       prev_cyc  = 1'b0;
    logic       prev_ack  = 1'b0;
    logic [10:0] prev_ctl = '0;
    logic [1:0] prev_adr  = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pic_service_ctrl #(
        .EDGEN_INIT(8'h5A),
        .POL_INIT  (8'h3C),
        .MASK_INIT (8'h10),
        .TIMEOUT   (6)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .m_cyc_o    (m_cyc_o),
        .m_stb_o    (m_stb_o),
        .m_we_o     (m_we_o),
        .m_adr_o    (m_adr_o),
        .m_dat_o    (m_dat_o),
        .m_dat_i    (m_dat_i),
        .m_ack_i    (m_ack_i),
        .int_i      (int_i),
        .eoi_i      (eoi_i),
        .vec_valid_o(vec_valid_o),
        .vec_o      (vec_o),
        .vec_ready_i(vec_ready_i),
        .init_done_o(init_done_o),
        .busy_o     (busy_o),
        .spurious_o (spurious_o),
        .err_o      (err_o)
    );

    assign m_dat_i = pend_val;

    always @(posedge clk) begin
        if (rst_i)
            m_ack_i <= 1'b0;
        else
            m_ack_i <= m_cyc_o && m_stb_o && !m_ack_i && !(nack_en && m_adr_o == nack_adr);
        if (m_ack_i && m_cyc_o && m_we_o)
            wr_log.push_back({m_adr_o, m_dat_o});
        if (spurious_o)
            spur_cnt <= spur_cnt + 1;
    end

    // Bus-protocol monitor: stb tracks cyc, request stable while held, drop right after ack.
    always @(posedge clk) begin
        if (m_stb_o !== m_cyc_o) bus_viol <= bus_viol + 1;
        else if (m_cyc_o && prev_cyc && {m_we_o, m_adr_o, m_dat_o} != prev_ctl) bus_viol <= bus_viol + 1;
        else if (m_cyc_o && prev_cyc && prev_ack) bus_viol <= bus_viol + 1;
        if (m_cyc_o) run <= run + 1;
        else if (run != 0) begin
            run_len[prev_adr] <= run;
            run <= 0;
        end
        prev_cyc <= m_cyc_o;
        prev_ack <= m_ack_i;
        prev_ctl <= {m_we_o, m_adr_o, m_dat_o};
        prev_adr <= m_adr_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc && busy_o; i++) @(negedge clk);
        check(tag, {31'b0, busy_o}, 32'd0);
    endtask

    task automatic wait_vv(input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc && !vec_valid_o; i++) @(negedge clk);
        check(tag, {31'b0, vec_valid_o}, 32'd1);
    endtask

    task automatic pulse_int();
        int_i = 1'b1;
        @(negedge clk);
        int_i = 1'b0;
    endtask

    task automatic service(input logic [7:0] pend, input logic [2:0] exp_g, input string tag);
        int base;
        logic [7:0] mask_bit;
        base = wr_log.size();
        mask_bit = 8'b1 << exp_g;
        pend_val = pend;
        pulse_int();
        wait_vv(40, {tag, "_vv"});
        check({tag, "_vec"}, {29'b0, vec_o}, {29'b0, exp_g});
        vec_ready_i = 1'b1;
        @(negedge clk);
        vec_ready_i = 1'b0;
        check({tag, "_vv_drop"}, {31'b0, vec_valid_o}, 32'd0);
        eoi_i = 1'b1;
        @(negedge clk);
        eoi_i = 1'b0;
        wait_idle(40, {tag, "_idle"});
        check({tag, "_nwr"}, wr_log.size(), base + 1);
        check({tag, "_clr"}, {22'b0, wr_log[base]}, {22'b0, 2'b11, mask_bit});
    endtask

    initial begin
        int base, spur0;
        rst_i = 1'b1; int_i = 1'b0; eoi_i = 1'b0; vec_ready_i = 1'b0;
        pend_val = 8'h00; nack_en = 1'b0; nack_adr = 2'b01;
        repeat (3) @(negedge clk);
        check("rst_outputs",
              {11'b0, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, vec_valid_o, vec_o,
               init_done_o, busy_o, spurious_o, err_o}, 32'd0);

        // Init sequence with a well-behaved slave.
        rst_i = 1'b0;
        @(negedge clk);
        check("init_first_wr", {20'b0, m_cyc_o, m_we_o, m_adr_o, m_dat_o}, {20'b0, 1'b1, 1'b1, 2'b00, 8'h5A});
        check("init_busy", {31'b0, busy_o}, 32'd1);
        wait_idle(60, "init_idle");
        check("init_done", {31'b0, init_done_o}, 32'd1);
        check("init_err", {31'b0, err_o}, 32'd0);
        check("init_nwr", wr_log.size(), 3);
        check("init_wr0", {22'b0, wr_log[0]}, {22'b0, 2'b00, 8'h5A});
        check("init_wr1", {22'b0, wr_log[1]}, {22'b0, 2'b01, 8'h3C});
        check("init_wr2", {22'b0, wr_log[2]}, {22'b0, 2'b10, 8'h10});

        // Round robin over pending 0x81: 0, 7, 0 (rr ends at 1).
        service(8'h81, 3'd0, "rr0");
        service(8'h81, 3'd7, "rr1");
        service(8'h81, 3'd0, "rr2");

        // Single pending bit 2, holding vec_ready low; eoi ignored in PRESENT and when coincident with ready.
        base = wr_log.size();
        pend_val = 8'h04;
        pulse_int();
        wait_vv(40, "svc_vv");
        check("svc_vec", {29'b0, vec_o}, 32'd2);
        eoi_i = 1'b1;
        repeat (2) @(negedge clk);
        check("svc_hold", {28'b0, vec_valid_o, vec_o}, {28'b0, 1'b1, 3'd2});
        vec_ready_i = 1'b1;
        @(negedge clk);
        vec_ready_i = 1'b0;
        eoi_i = 1'b0;
        check("svc_vv_drop", {31'b0, vec_valid_o}, 32'd0);
        repeat (3) @(negedge clk);
        check("svc_eoi_forgot", {wr_log.size() - base, 31'b0} >> 31 | {31'b0, busy_o}, 32'd1);
        check("svc_no_clr", wr_log.size(), base);
        eoi_i = 1'b1;
        @(negedge clk);
        eoi_i = 1'b0;
        wait_idle(40, "svc_idle");
        check("svc_nwr", wr_log.size(), base + 1);
        check("svc_clr", {22'b0, wr_log[base]}, {22'b0, 2'b11, 8'h04});

        // Spurious: nothing pending, then only a masked bit pending.
        base = wr_log.size();
        spur0 = spur_cnt;
        pend_val = 8'h00;
        pulse_int();
        wait_idle(40, "spur0_idle");
        repeat (2) @(negedge clk);
        check("spur0_pulse", spur_cnt - spur0, 1);
        pend_val = 8'h10;
        pulse_int();
        wait_idle(40, "spur1_idle");
        repeat (2) @(negedge clk);
        check("spur1_pulse", spur_cnt - spur0, 2);
        check("spur_no_wr", wr_log.size(), base);
        check("spur_vv", {31'b0, vec_valid_o}, 32'd0);

        // rr=3, masked bit 4 is skipped in favour of bit 5.
        service(8'h30, 3'd5, "mask_skip");
        // rr=6, wraps to bit 0.
        base = wr_log.size();
        pend_val = 8'h01;
        pulse_int();
        wait_vv(40, "wrap_vv");
        check("wrap_vec", {29'b0, vec_o}, 32'd0);
        vec_ready_i = 1'b1;
        @(negedge clk);
        vec_ready_i = 1'b0;

        // Reset while waiting for EOI.
        rst_i = 1'b1;
        @(negedge clk);
        check("rst_weoi", {29'b0, vec_valid_o, busy_o, m_cyc_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_reinit_start", {28'b0, m_cyc_o, m_adr_o, busy_o}, {28'b0, 1'b1, 2'b00, 1'b1});
        wait_idle(60, "reinit_idle");
        check("reinit_nwr", wr_log.size(), base + 3);
        check("reinit_done", {31'b0, init_done_o}, 32'd1);
        service(8'h81, 3'd0, "rr_after_rst");

        // Timeout: slave never acks the polarity write.
        base = wr_log.size();
        nack_en = 1'b1;
        nack_adr = 2'b01;
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        wait_idle(80, "tmo_idle");
        check("tmo_err", {31'b0, err_o}, 32'd1);
        check("tmo_done", {31'b0, init_done_o}, 32'd0);
        check("tmo_cyc_len", run_len[1], 6);
        check("tmo_nwr", wr_log.size(), base + 2);
        check("tmo_wr_edge", {22'b0, wr_log[base]}, {22'b0, 2'b00, 8'h5A});
        check("tmo_wr_mask", {22'b0, wr_log[base + 1]}, {22'b0, 2'b10, 8'h10});
        nack_en = 1'b0;
        service(8'h02, 3'd1, "post_tmo");
        check("err_sticky", {31'b0, err_o}, 32'd1);

        check("bus_protocol", bus_viol, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
